// File: rtl/current_steering_ctrl_pkg.sv
// Shared state type, array sizes and thermometer decode helper for the
// current-steering DAC controller.
package current_steering_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PWRUP = 2'd1,
    ST_CAL   = 2'd2,
    ST_RUN   = 2'd3
  } cs_state_e;

  localparam int         N_THERM    = 17;
  localparam int         N_BIN      = 6;
  localparam int         CODE_W     = 11;
  localparam logic [10:0] CODE_MAX  = 11'd1151;
  localparam logic [4:0] ICAL_RESET = 5'd16;

  // Thermometer fill: the n lowest cells on, LSB first (n = 0..17).
  function automatic logic [N_THERM-1:0] therm_decode(input logic [4:0] n);
    logic [N_THERM-1:0] t;
    for (int i = 0; i < N_THERM; i++) begin
      t[i] = (5'(i) < n);
    end
    return t;
  endfunction

endpackage

// File: rtl/current_steering_ctrl_cs_sar_cal.sv
// 5-bit successive-approximation search of the Ical trim against an external
// comparator. Each trial code is held SETTLE_CYC cycles and the comparator is
// sampled on the last one. An abort restores the last completed result.
module cs_sar_cal
  import current_steering_pkg::*;
#(
  parameter int SETTLE_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       cmp_in,
  output logic [4:0] dataical,
  output logic       done
);

  localparam int              CNT_W    = $clog2(SETTLE_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

  logic [4:0]       sar_q, sar_d;
  logic [4:0]       saved_q, saved_d;
  logic [4:0]       trial_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic             active_q, active_d;
  logic             done_q, done_d;

  // SAR step: abort has priority, then start, then settle/decide per bit.
  always_comb begin
    sar_d    = sar_q;
    saved_d  = saved_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    active_d = active_q;
    done_d   = 1'b0;
    trial_s  = sar_q;
    if (abort) begin
      sar_d    = saved_q;
      cnt_d    = {CNT_W{1'b0}};
      bit_d    = 3'd4;
      active_d = 1'b0;
    end else if (start) begin
      sar_d    = 5'b10000;
      cnt_d    = {CNT_W{1'b0}};
      bit_d    = 3'd4;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == CNT_LAST) begin
        // Comparator high means the trial overshoots: drop the bit.
        if (cmp_in) begin
          trial_s[bit_q] = 1'b0;
        end else begin
          trial_s[bit_q] = 1'b1;
        end
        cnt_d = {CNT_W{1'b0}};
        if (bit_q == 3'd0) begin
          sar_d    = trial_s;
          saved_d  = trial_s;
          active_d = 1'b0;
          done_d   = 1'b1;
        end else begin
          trial_s[bit_q - 3'd1] = 1'b1;
          sar_d = trial_s;
          bit_d = bit_q - 3'd1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      sar_d = sar_q;
    end
  end

  // SAR state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sar_q    <= ICAL_RESET;
      saved_q  <= ICAL_RESET;
      cnt_q    <= {CNT_W{1'b0}};
      bit_q    <= 3'd4;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      sar_q    <= sar_d;
      saved_q  <= saved_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  assign dataical = sar_q;
  assign done     = done_q;

endmodule

// File: rtl/current_steering_ctrl.sv
// Controller for the 17-thermometer + 6-binary current-steering DAC: power-up
// sequencing, SAR trim calibration and registered complementary code drive.
module current_steering_ctrl
  import current_steering_pkg::*;
#(
  parameter int PWRUP_CYC  = 64,
  parameter int SETTLE_CYC = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               cal_req,
  input  logic               cmp_in,
  input  logic               code_valid,
  input  logic [CODE_W-1:0]  code,
  output logic               code_ready,
  input  logic               redund_en,
  input  logic [1:0]         atb_sel,
  input  logic               atest_req,
  output logic               pdb,
  output logic [N_BIN:0]     datain,
  output logic [N_BIN:0]     datainb,
  output logic [N_THERM-1:0] datatherm,
  output logic [N_THERM-1:0] datathermb,
  output logic [4:0]         dataical,
  output logic [1:0]         atb_ena,
  output logic               atest_ena,
  output logic               busy,
  output logic               cal_done
);

  localparam int              PWR_W    = $clog2(PWRUP_CYC) + 1;
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWRUP_CYC - 1);

  cs_state_e          state_q, state_d;
  logic [PWR_W-1:0]   pwr_cnt_q, pwr_cnt_d;
  logic               start_cal_s;
  logic               accept_s;
  logic               sar_done_s;
  logic [CODE_W-1:0]  code_clip_s;
  logic [N_BIN:0]     datain_q, datain_d;
  logic [N_BIN:0]     datainb_q, datainb_d;
  logic [N_THERM-1:0] datatherm_q, datatherm_d;
  logic [N_THERM-1:0] datathermb_q, datathermb_d;
  logic               pdb_q, pdb_d;
  logic               busy_q, busy_d;
  logic [1:0]         atb_q, atb_d;
  logic               atest_q, atest_d;

  assign code_ready = (state_q == ST_RUN) & enable;
  assign accept_s   = code_valid & code_ready;

  cs_sar_cal #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_sar (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start_cal_s),
    .abort    (~enable),
    .cmp_in   (cmp_in),
    .dataical (dataical),
    .done     (sar_done_s)
  );

  // Mode sequencing; dropping enable returns to IDLE from anywhere.
  always_comb begin
    state_d     = state_q;
    pwr_cnt_d   = {PWR_W{1'b0}};
    start_cal_s = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_PWRUP;
        end
        ST_PWRUP: begin
          if (pwr_cnt_q == PWR_LAST) begin
            state_d     = ST_CAL;
            start_cal_s = 1'b1;
          end else begin
            pwr_cnt_d = pwr_cnt_q + PWR_W'(1);
          end
        end
        ST_CAL: begin
          if (sar_done_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_CAL;
          end
        end
        ST_RUN: begin
          if (cal_req) begin
            state_d     = ST_CAL;
            start_cal_s = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Code decode, zero code outside RUN, and pdb-gated test-bus controls.
  always_comb begin
    code_clip_s = (code > CODE_MAX) ? CODE_MAX : code;
    if (accept_s) begin
      datatherm_d = therm_decode(code_clip_s[CODE_W-1:N_BIN]);
      datain_d    = {redund_en, code_clip_s[N_BIN-1:0]};
    end else if (state_d == ST_RUN) begin
      datatherm_d = datatherm_q;
      datain_d    = datain_q;
    end else begin
      datatherm_d = {N_THERM{1'b0}};
      datain_d    = {(N_BIN + 1){1'b0}};
    end
    datathermb_d = ~datatherm_d;
    datainb_d    = ~datain_d;
    pdb_d        = (state_d != ST_IDLE);
    busy_d       = (state_d == ST_PWRUP) || (state_d == ST_CAL);
    if (pdb_d) begin
      atb_d   = atb_sel;
      atest_d = atest_req;
    end else begin
      atb_d   = 2'b00;
      atest_d = 1'b0;
    end
  end

  // Controller registers; every macro control comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pwr_cnt_q    <= {PWR_W{1'b0}};
      datain_q     <= {(N_BIN + 1){1'b0}};
      datainb_q    <= {(N_BIN + 1){1'b1}};
      datatherm_q  <= {N_THERM{1'b0}};
      datathermb_q <= {N_THERM{1'b1}};
      pdb_q        <= 1'b0;
      busy_q       <= 1'b0;
      atb_q        <= 2'b00;
      atest_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pwr_cnt_q    <= pwr_cnt_d;
      datain_q     <= datain_d;
      datainb_q    <= datainb_d;
      datatherm_q  <= datatherm_d;
      datathermb_q <= datathermb_d;
      pdb_q        <= pdb_d;
      busy_q       <= busy_d;
      atb_q        <= atb_d;
      atest_q      <= atest_d;
    end
  end

  assign pdb        = pdb_q;
  assign datain     = datain_q;
  assign datainb    = datainb_q;
  assign datatherm  = datatherm_q;
  assign datathermb = datathermb_q;
  assign atb_ena    = atb_q;
  assign atest_ena  = atest_q;
  assign busy       = busy_q;
  assign cal_done   = sar_done_s;

endmodule

// File: tb/tb_current_steering_ctrl.sv
// Randomized scoreboard bench for current_steering_ctrl. The driver applies one
// input vector per cycle, a behavioural model predicts the outputs after the
// next edge and queues them; a monitor on the falling edge pops and compares.
module tb_current_steering_ctrl;

  localparam int PWRUP_CYC  = 64;
  localparam int SETTLE_CYC = 16;
  localparam int M_IDLE = 0, M_PWRUP = 1, M_CAL = 2, M_RUN = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        enable = 1'b0, cal_req = 1'b0, cmp_in = 1'b0, code_valid = 1'b0;
  logic        redund_en = 1'b0, atest_req = 1'b0;
  logic [10:0] code = 11'd0;
  logic [1:0]  atb_sel = 2'b00;
  logic        code_ready, pdb, atest_ena, busy, cal_done;
  logic [6:0]  datain, datainb;
  logic [16:0] datatherm, datathermb;
  logic [4:0]  dataical;
  logic [1:0]  atb_ena;

  current_steering_ctrl #(.PWRUP_CYC(PWRUP_CYC), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cal_req(cal_req), .cmp_in(cmp_in),
    .code_valid(code_valid), .code(code), .code_ready(code_ready),
    .redund_en(redund_en), .atb_sel(atb_sel), .atest_req(atest_req),
    .pdb(pdb), .datain(datain), .datainb(datainb), .datatherm(datatherm),
    .datathermb(datathermb), .dataical(dataical), .atb_ena(atb_ena),
    .atest_ena(atest_ena), .busy(busy), .cal_done(cal_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        pdb;
    logic [6:0]  din;
    logic [6:0]  dinb;
    logic [16:0] therm;
    logic [16:0] thermb;
    logic [4:0]  ical;
    logic [1:0]  atb;
    logic        atest;
    logic        busy;
    logic        done;
    logic        run;
  } exp_t;

  exp_t sb_q[$];
  int   tick = 0;
  int   n_vec = 0;
  int   n_mis = 0;

  always @(posedge clk) tick <= tick + 1;

  // Reference model state: mode, elapsed counts and SAR bookkeeping.
  int          ms, pwr, cal_e, thr;
  logic [4:0]  cal_bits, saved, ical;
  logic [16:0] therm;
  logic [6:0]  din;
  logic        cal_fin;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at tick %0d: got 0x%0h, expected 0x%0h", name, tick, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tg);
    chk({tg, "_pdb"}, pdb, 0);
    chk({tg, "_datain"}, datain, 0);
    chk({tg, "_datainb"}, datainb, 32'h7F);
    chk({tg, "_datatherm"}, datatherm, 0);
    chk({tg, "_datathermb"}, datathermb, 32'h1FFFF);
    chk({tg, "_dataical"}, dataical, 16);
    chk({tg, "_atb_ena"}, atb_ena, 0);
    chk({tg, "_atest_ena"}, atest_ena, 0);
    chk({tg, "_busy"}, busy, 0);
    chk({tg, "_cal_done"}, cal_done, 0);
  endtask

  task automatic model_reset();
    ms = M_IDLE; pwr = 0; cal_e = 0; cal_bits = 5'd0;
    saved = 5'd16; ical = 5'd16; therm = 17'd0; din = 7'd0; cal_fin = 1'b0;
  endtask

  task automatic model_start_cal();
    cal_e = 0; cal_bits = 5'd0; ical = 5'd16; cal_fin = 1'b0;
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic model_step();
    exp_t e;
    int   ns, c, b, step;
    bit   accept, done_m;
    accept = (ms == M_RUN) && enable && code_valid;
    ns = ms;
    done_m = 1'b0;
    if (!enable) begin
      ns = M_IDLE; ical = saved; cal_fin = 1'b0;
    end else begin
      case (ms)
        M_IDLE: begin ns = M_PWRUP; pwr = 0; end
        M_PWRUP: begin
          pwr++;
          if (pwr == PWRUP_CYC) begin ns = M_CAL; model_start_cal(); end
        end
        M_CAL: begin
          if (cal_fin) begin
            ns = M_RUN; cal_fin = 1'b0;
          end else begin
            cal_e++;
            if (cal_e % SETTLE_CYC == 0) begin
              step = cal_e / SETTLE_CYC;
              b = 5 - step;
              if (!cmp_in) cal_bits[b] = 1'b1;
              if (b == 0) begin
                ical = cal_bits; saved = cal_bits; cal_fin = 1'b1; done_m = 1'b1;
              end else begin
                ical = cal_bits | 5'(1 << (b - 1));
              end
            end
          end
        end
        M_RUN: if (cal_req) begin ns = M_CAL; model_start_cal(); end
        default: ns = M_IDLE;
      endcase
    end
    if (accept) begin
      c = (int'(code) > 1151) ? 1151 : int'(code);
      therm = 17'((1 << (c / 64)) - 1);
      din = {redund_en, 6'(c % 64)};
    end else if (ns != M_RUN) begin
      therm = 17'd0; din = 7'd0;
    end
    ms = ns;
    e.tag = tick + 1;
    e.pdb = (ns != M_IDLE);
    e.din = din;
    e.dinb = ~din;
    e.therm = therm;
    e.thermb = ~therm;
    e.ical = ical;
    e.atb = e.pdb ? atb_sel : 2'b00;
    e.atest = e.pdb ? atest_req : 1'b0;
    e.busy = (ns == M_PWRUP) || (ns == M_CAL);
    e.done = done_m;
    e.run = (ns == M_RUN);
    sb_q.push_back(e);
  endtask

  // One clock of stimulus: comparator follows the model's trim vs threshold.
  task automatic cycle();
    cmp_in = (int'(ical) > thr);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_misc();
    code_valid = ($urandom_range(0, 3) != 0);
    code = 11'($urandom_range(0, 2047));
    redund_en = 1'($urandom_range(0, 1));
    atb_sel = 2'($urandom_range(0, 3));
    atest_req = 1'($urandom_range(0, 1));
  endtask

  task automatic apply_code(input int cv, input bit red);
    code_valid = 1'b1; code = 11'(cv); redund_en = red;
    cycle();
  endtask

  // Monitor: compare every queued prediction once its edge has happened.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb_q.size() > 0 && sb_q[0].tag <= tick) begin
        e = sb_q.pop_front();
        chk("pdb", pdb, e.pdb);
        chk("datain", datain, e.din);
        chk("datainb", datainb, e.dinb);
        chk("datatherm", datatherm, e.therm);
        chk("datathermb", datathermb, e.thermb);
        chk("dataical", dataical, e.ical);
        chk("atb_ena", atb_ena, e.atb);
        chk("atest_ena", atest_ena, e.atest);
        chk("busy", busy, e.busy);
        chk("cal_done", cal_done, e.done);
        chk("code_ready", code_ready, e.run & enable);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    thr = 11;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // IDLE with a test-bus request: gated off.
    atb_sel = 2'b10; atest_req = 1'b1;
    repeat (4) cycle();

    // Power-up and first calibration (threshold 11), noisy code inputs.
    enable = 1'b1;
    for (int i = 0; i < 1 + PWRUP_CYC + 5 * SETTLE_CYC + 1; i++) begin
      rand_misc();
      cal_req = ($urandom_range(0, 7) == 0);
      cycle();
    end
    cal_req = 1'b0;

    // Directed codes in RUN.
    atb_sel = 2'b10; atest_req = 1'b1;
    apply_code(130, 1'b0);
    apply_code(1151, 1'b0);
    apply_code(2000, 1'b0);
    apply_code(130, 1'b1);
    apply_code(0, 1'b0);
    code_valid = 1'b0;
    repeat (2) cycle();

    // Random streaming in RUN.
    for (int i = 0; i < 200; i++) begin rand_misc(); cycle(); end

    // Recalibrations with back-to-back valid codes.
    for (int r = 0; r < 3; r++) begin
      thr = (r == 2) ? 11 : $urandom_range(0, 31);
      rand_misc(); code_valid = 1'b1; cal_req = 1'b1;
      cycle();
      cal_req = 1'b0;
      for (int i = 0; i < 5 * SETTLE_CYC + 4; i++) begin
        rand_misc(); code_valid = 1'b1; cycle();
      end
    end

    // Abort during the third SAR step after a result of 11.
    thr = 20; cal_req = 1'b1;
    cycle();
    cal_req = 1'b0;
    repeat (2 * SETTLE_CYC + 5) cycle();
    enable = 1'b0;
    repeat (5) cycle();

    // Random soak: enable drops, recal requests, threshold changes.
    enable = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      rand_misc();
      cal_req = ($urandom_range(0, 63) == 0);
      if (cal_req) thr = $urandom_range(0, 31);
      if (enable) enable = ($urandom_range(0, 199) != 0);
      else enable = ($urandom_range(0, 3) == 0);
      cycle();
    end
    cal_req = 1'b0;

    // Asynchronous reset mid-operation.
    enable = 1'b1;
    repeat (100) begin rand_misc(); cycle(); end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    sb_q.delete();
    model_reset();
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (3) cycle();
    enable = 1'b1;
    repeat (20) begin rand_misc(); cycle(); end

    // Drain the scoreboard.
    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
